// File: rtl/result_capture_unit_if.sv
// Handshake and result bus between the operand wrapper, the compute block and the capture unit.
// The slave modport is the capture unit's view; master is the driver/observer side.
interface result_capture_unit_if;
   logic        start;
   logic        done;
   logic [15:0] g;
   logic [15:0] h;
   logic        sel;
   logic [15:0] disp;
   logic [4:0]  pop_cnt;
   logic        par_bit;
   logic [15:0] latency;
   logic        busy;
   logic        valid;
   logic        timeout;
   logic        seq_err;

   modport master (
      output start, done, g, h, sel,
      input  disp, pop_cnt, par_bit, latency, busy, valid, timeout, seq_err
   );

   modport slave (
      input  start, done, g, h, sel,
      output disp, pop_cnt, par_bit, latency, busy, valid, timeout, seq_err
   );
endinterface

// File: rtl/result_capture_unit.sv
// Times start-to-done latency, latches the two compute results, bit-serially
// pop-counts them over 16 cycles, then presents the selected result with parity.
module result_capture_unit (
   input logic                  clk,
   input logic                  rst,
   result_capture_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, TIMING, COUNT, HOLD} state_t;

   state_t      state_q, state_d;
   logic        start_q;
   logic [15:0] g_lat_q, g_lat_d;
   logic [15:0] h_lat_q, h_lat_d;
   logic [15:0] sh_g_q, sh_g_d;
   logic [15:0] sh_h_q, sh_h_d;
   logic [4:0]  pop_g_q, pop_g_d;
   logic [4:0]  pop_h_q, pop_h_d;
   logic [3:0]  cyc_q, cyc_d;
   logic [15:0] lat_q, lat_d;
   logic        timeout_q, timeout_d;
   logic        seq_err_q, seq_err_d;
   logic        start_rise;
   logic [4:0]  pop_sel;

   assign start_rise = bus.start & ~start_q;

   always_comb begin
      state_d   = state_q;
      g_lat_d   = g_lat_q;
      h_lat_d   = h_lat_q;
      sh_g_d    = sh_g_q;
      sh_h_d    = sh_h_q;
      pop_g_d   = pop_g_q;
      pop_h_d   = pop_h_q;
      cyc_d     = cyc_q;
      lat_d     = lat_q;
      timeout_d = timeout_q;
      seq_err_d = seq_err_q | (bus.done & ~bus.start);

      // The latency register doubles as the live edge counter while TIMING.
      unique case (state_q)
         IDLE: begin
            if (start_rise) begin
               lat_d = 16'd0;
               if (bus.done) begin
                  g_lat_d = bus.g;
                  h_lat_d = bus.h;
                  sh_g_d  = bus.g;
                  sh_h_d  = bus.h;
                  pop_g_d = 5'd0;
                  pop_h_d = 5'd0;
                  cyc_d   = 4'd0;
                  state_d = COUNT;
               end else begin
                  state_d = TIMING;
               end
            end
         end
         TIMING: begin
            if (!bus.start) begin
               state_d = IDLE;
            end else begin
               lat_d = (lat_q == 16'hFFFF) ? 16'hFFFF : lat_q + 16'd1;
               if (lat_d == 16'hFFFF) begin
                  timeout_d = 1'b1;
               end
               if (bus.done) begin
                  g_lat_d = bus.g;
                  h_lat_d = bus.h;
                  sh_g_d  = bus.g;
                  sh_h_d  = bus.h;
                  pop_g_d = 5'd0;
                  pop_h_d = 5'd0;
                  cyc_d   = 4'd0;
                  state_d = COUNT;
               end
            end
         end
         COUNT: begin
            if (!bus.start) begin
               state_d = IDLE;
            end else begin
               pop_g_d = pop_g_q + {4'd0, sh_g_q[0]};
               pop_h_d = pop_h_q + {4'd0, sh_h_q[0]};
               sh_g_d  = {1'b0, sh_g_q[15:1]};
               sh_h_d  = {1'b0, sh_h_q[15:1]};
               cyc_d   = cyc_q + 4'd1;
               if (cyc_q == 4'd15) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (!bus.start) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         start_q   <= 1'b0;
         g_lat_q   <= 16'd0;
         h_lat_q   <= 16'd0;
         sh_g_q    <= 16'd0;
         sh_h_q    <= 16'd0;
         pop_g_q   <= 5'd0;
         pop_h_q   <= 5'd0;
         cyc_q     <= 4'd0;
         lat_q     <= 16'd0;
         timeout_q <= 1'b0;
         seq_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         start_q   <= bus.start;
         g_lat_q   <= g_lat_d;
         h_lat_q   <= h_lat_d;
         sh_g_q    <= sh_g_d;
         sh_h_q    <= sh_h_d;
         pop_g_q   <= pop_g_d;
         pop_h_q   <= pop_h_d;
         cyc_q     <= cyc_d;
         lat_q     <= lat_d;
         timeout_q <= timeout_d;
         seq_err_q <= seq_err_d;
      end
   end

   // Result outputs are live on sel only in HOLD; elsewhere they read zero.
   always_comb begin
      pop_sel     = bus.sel ? pop_g_q : pop_h_q;
      bus.disp    = 16'd0;
      bus.pop_cnt = 5'd0;
      bus.par_bit = 1'b0;
      if (state_q == HOLD) begin
         bus.disp    = bus.sel ? g_lat_q : h_lat_q;
         bus.pop_cnt = pop_sel;
         bus.par_bit = ~pop_sel[0];
      end
   end

   assign bus.latency = lat_q;
   assign bus.busy    = (state_q == TIMING) || (state_q == COUNT);
   assign bus.valid   = (state_q == HOLD);
   assign bus.timeout = timeout_q;
   assign bus.seq_err = seq_err_q;

endmodule

// File: tb/tb_result_capture_unit.sv
// Directed, table-driven bench for result_capture_unit: each record sets the
// inputs, advances a number of clock edges and then checks every output.
module tb_result_capture_unit;

   typedef struct {
      string       name;
      logic        start;
      logic        done;
      logic [15:0] g;
      logic [15:0] h;
      logic        sel;
      int          edges;
      logic [15:0] e_disp;
      logic [4:0]  e_pop;
      logic        e_par;
      logic [15:0] e_lat;
      logic        e_busy;
      logic        e_valid;
      logic        e_timeout;
      logic        e_seq;
   } vec_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   vec_t vecs[$];
   vec_t v;

   result_capture_unit_if bus();

   result_capture_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1ns after a rising edge; outputs are checked at that same point.
   task automatic applyStimulus(input vec_t s);
      bus.start = s.start;
      bus.done  = s.done;
      bus.g     = s.g;
      bus.h     = s.h;
      bus.sel   = s.sel;
      if (s.edges == 0) begin
         #1;
      end else begin
         repeat (s.edges) @(posedge clk);
         #1;
      end
   endtask

   task automatic cmp(input string vname, input string field, input logic [15:0] act, input logic [15:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s.%s: got %h, expected %h", vname, field, act, exp);
      end
   endtask

   task automatic checkOutput(input vec_t s);
      vectors++;
      cmp(s.name, "disp",    bus.disp,             s.e_disp);
      cmp(s.name, "pop_cnt", {11'd0, bus.pop_cnt}, {11'd0, s.e_pop});
      cmp(s.name, "par_bit", {15'd0, bus.par_bit}, {15'd0, s.e_par});
      cmp(s.name, "latency", bus.latency,          s.e_lat);
      cmp(s.name, "busy",    {15'd0, bus.busy},    {15'd0, s.e_busy});
      cmp(s.name, "valid",   {15'd0, bus.valid},   {15'd0, s.e_valid});
      cmp(s.name, "timeout", {15'd0, bus.timeout}, {15'd0, s.e_timeout});
      cmp(s.name, "seq_err", {15'd0, bus.seq_err}, {15'd0, s.e_seq});
   endtask

   task automatic runVec(input vec_t s);
      applyStimulus(s);
      checkOutput(s);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;

      // name, start, done, g, h, sel, edges, disp, pop, par, lat, busy, valid, timeout, seq_err
      vecs.push_back('{"idle",        1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1,  2, 16'h0000, 5'd0,  1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"b_rise",      1'b1, 1'b0, 16'h00FF, 16'h8001, 1'b1,  1, 16'h0000, 5'd0,  1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"b_timing",    1'b1, 1'b0, 16'h00FF, 16'h8001, 1'b1,  4, 16'h0000, 5'd0,  1'b0, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"b_capture",   1'b1, 1'b1, 16'h00FF, 16'h8001, 1'b1,  1, 16'h0000, 5'd0,  1'b0, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"b_count15",   1'b1, 1'b0, 16'h1234, 16'hFFFF, 1'b1, 15, 16'h0000, 5'd0,  1'b0, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"b_hold_g",    1'b1, 1'b0, 16'h1234, 16'hFFFF, 1'b1,  1, 16'h00FF, 5'd8,  1'b1, 16'd5, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{"b_hold_h",    1'b1, 1'b0, 16'h1234, 16'hFFFF, 1'b0,  0, 16'h8001, 5'd2,  1'b1, 16'd5, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{"b_release",   1'b0, 1'b0, 16'h1234, 16'hFFFF, 1'b1,  1, 16'h0000, 5'd0,  1'b0, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"s_capture",   1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b1,  1, 16'h0000, 5'd0,  1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"s_count15",   1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 15, 16'h0000, 5'd0,  1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"s_hold_g",    1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1,  1, 16'hFFFF, 5'd16, 1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{"s_hold_h",    1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0,  0, 16'h0000, 5'd0,  1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{"s_release",   1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1,  1, 16'h0000, 5'd0,  1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"e_pulse",     1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1,  1, 16'h0000, 5'd0,  1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{"e_idle",      1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1,  2, 16'h0000, 5'd0,  1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{"e_rise",      1'b1, 1'b0, 16'h0F0F, 16'h0007, 1'b1,  1, 16'h0000, 5'd0,  1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{"e_capture",   1'b1, 1'b1, 16'h0F0F, 16'h0007, 1'b1,  1, 16'h0000, 5'd0,  1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{"e_hold_g",    1'b1, 1'b0, 16'h0F0F, 16'h0007, 1'b1, 16, 16'h0F0F, 5'd8,  1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{"e_hold_h",    1'b1, 1'b0, 16'h0F0F, 16'h0007, 1'b0,  0, 16'h0007, 5'd3,  1'b0, 16'd1, 1'b0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{"e_release",   1'b0, 1'b0, 16'h0F0F, 16'h0007, 1'b1,  1, 16'h0000, 5'd0,  1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1});

      rst       = 1'b0;
      bus.start = 1'b0;
      bus.done  = 1'b0;
      bus.g     = 16'h0000;
      bus.h     = 16'h0000;
      bus.sel   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      v = '{"reset", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 16'h0000, 5'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      checkOutput(v);
      rst = 1'b1;

      $display("[TB] applying %0d table vectors", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         runVec(vecs[i]);
      end

      // Reset 8 edges into COUNT, with start held high through the release.
      v = '{"a_capture", 1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1, 16'h0000, 5'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1};
      runVec(v);
      v = '{"a_count7",  1'b1, 1'b0, 16'hAAAA, 16'h5555, 1'b1, 7, 16'h0000, 5'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1};
      runVec(v);
      rst = 1'b0;
      v = '{"a_inreset", 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 0, 16'h0000, 5'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      runVec(v);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      v = '{"a_rise",    1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1, 16'h0000, 5'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      runVec(v);
      v = '{"a_capture2",1'b1, 1'b1, 16'h0001, 16'h0000, 1'b1, 1, 16'h0000, 5'd0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0};
      runVec(v);
      v = '{"a_hold_g",  1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 16, 16'h0001, 5'd1, 1'b0, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0};
      runVec(v);
      v = '{"a_hold_h",  1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 0, 16'h0000, 5'd0, 1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0};
      runVec(v);
      v = '{"a_release", 1'b0, 1'b0, 16'h0001, 16'h0000, 1'b1, 1, 16'h0000, 5'd0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      runVec(v);

      // Done never arrives: the counter must pin at FFFF and raise timeout.
      v = '{"t_rise",    1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1, 16'h0000, 5'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      runVec(v);
      v = '{"t_fffe",    1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 65534, 16'h0000, 5'd0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0};
      runVec(v);
      v = '{"t_ffff",    1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1, 16'h0000, 5'd0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
      runVec(v);
      v = '{"t_pinned",  1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 5, 16'h0000, 5'd0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
      runVec(v);
      v = '{"t_release", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1, 16'h0000, 5'd0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
      runVec(v);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
